// File: rtl/pulse_sequencer.sv
// Circular N-phase pulse distributor with per-phase start/memory-read wait masks.
// Optional memory-reply timeout and ERROR state enabled by `define PULSE_SEQ_TIMEOUT_EN.
module pulse_sequencer #(
  parameter int unsigned NPHASE = 8,
  parameter int unsigned TO_W   = 8,
  parameter int unsigned TO_CYC = 200,
  localparam int unsigned PW    = $clog2(NPHASE)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NPHASE-1:0] wait_start_mask,
  input  logic [NPHASE-1:0] mem_read_mask,
  input  logic              start_pulse,
  input  logic              mem_reply,
  input  logic              err_clear,
  output logic [PW-1:0]     cur_phase,
  output logic [NPHASE-1:0] at_phase,
  output logic [NPHASE-1:0] entering_phase,
  output logic              mem_read,
  output logic [NPHASE-1:0] mem_data_valid,
  output logic              operate_pulse,
  output logic              mem_timeout
);

  typedef enum logic [0:0] {StRun, StError} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          first_q, first_d;
  logic          wait_q, wait_d;
  logic          mem_q, mem_d;
  logic          got_start_q, got_start_d;
  logic          got_reply_q, got_reply_d;

  logic          run;
  logic          wait_eff;
  logic          mem_eff;
  logic          start_acc;
  logic          reply_acc;
  logic          advance;
  logic [PW-1:0] next_phase;

  assign run = (state_q == StRun);

  // On the first cycle of a phase the live mask bits stand in for the latched ones.
  assign wait_eff = first_q ? wait_start_mask[phase_q] : wait_q;
  assign mem_eff  = first_q ? mem_read_mask[phase_q]   : mem_q;

  assign start_acc = run && wait_eff && start_pulse;
  assign reply_acc = run && mem_eff && !got_reply_q && mem_reply;
  assign advance   = run && (!mem_eff || got_reply_q || mem_reply)
                         && (!wait_eff || got_start_q || start_pulse);

  assign next_phase = (phase_q == PW'(NPHASE - 1)) ? '0 : phase_q + PW'(1);

  assign cur_phase      = phase_q;
  assign at_phase       = run ? (NPHASE'(1) << phase_q) : '0;
  assign entering_phase = advance ? (NPHASE'(1) << next_phase) : '0;
  assign mem_read       = run && first_q && mem_read_mask[phase_q];
  assign mem_data_valid = reply_acc ? (NPHASE'(1) << phase_q) : '0;
  assign operate_pulse  = run && (phase_q == PW'(NPHASE - 1));

`ifdef PULSE_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tmo_q, tmo_d;

  assign mem_timeout = tmo_q;
`else
  logic            unused_err_clear;
  logic [TO_W-1:0] unused_to_cyc;

  assign unused_err_clear = err_clear;
  assign unused_to_cyc    = TO_W'(TO_CYC);
  assign mem_timeout      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    first_d     = 1'b0;
    wait_d      = wait_eff;
    mem_d       = mem_eff;
    got_start_d = got_start_q | start_acc;
    got_reply_d = got_reply_q | reply_acc;
`ifdef PULSE_SEQ_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    tmo_d       = tmo_q;
`endif
    if (run) begin
      if (advance) begin
        phase_d     = next_phase;
        first_d     = 1'b1;
        wait_d      = 1'b0;
        mem_d       = 1'b0;
        got_start_d = 1'b0;
        got_reply_d = 1'b0;
`ifdef PULSE_SEQ_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
      end
`ifdef PULSE_SEQ_TIMEOUT_EN
      // A reply on the cycle the count hits the limit wins over the timeout.
      else if (mem_eff && !got_reply_q && !mem_reply) begin
        if (to_cnt_q == TO_W'(TO_CYC)) begin
          state_d = StError;
          tmo_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
`endif
    end
`ifdef PULSE_SEQ_TIMEOUT_EN
    else if (err_clear) begin
      // Re-enter the frozen phase as if freshly entered so the read is re-issued.
      state_d     = StRun;
      first_d     = 1'b1;
      wait_d      = 1'b0;
      mem_d       = 1'b0;
      got_start_d = 1'b0;
      got_reply_d = 1'b0;
      to_cnt_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StRun;
      phase_q     <= '0;
      first_q     <= 1'b1;
      wait_q      <= 1'b0;
      mem_q       <= 1'b0;
      got_start_q <= 1'b0;
      got_reply_q <= 1'b0;
`ifdef PULSE_SEQ_TIMEOUT_EN
      to_cnt_q    <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      first_q     <= first_d;
      wait_q      <= wait_d;
      mem_q       <= mem_d;
      got_start_q <= got_start_d;
      got_reply_q <= got_reply_d;
`ifdef PULSE_SEQ_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer (NPHASE=8, TO_CYC=5): per-cycle expectations are
// queued as stimulus is driven and compared at the following falling edge.
module tb_pulse_sequencer;

  logic       clk;
  logic       resetn;
  logic [7:0] wait_start_mask;
  logic [7:0] mem_read_mask;
  logic       start_pulse;
  logic       mem_reply;
  logic       err_clear;
  logic [2:0] cur_phase;
  logic [7:0] at_phase;
  logic [7:0] entering_phase;
  logic       mem_read;
  logic [7:0] mem_data_valid;
  logic       operate_pulse;
  logic       mem_timeout;

  pulse_sequencer #(
    .NPHASE (8),
    .TO_W   (8),
    .TO_CYC (5)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .wait_start_mask (wait_start_mask),
    .mem_read_mask   (mem_read_mask),
    .start_pulse     (start_pulse),
    .mem_reply       (mem_reply),
    .err_clear       (err_clear),
    .cur_phase       (cur_phase),
    .at_phase        (at_phase),
    .entering_phase  (entering_phase),
    .mem_read        (mem_read),
    .mem_data_valid  (mem_data_valid),
    .operate_pulse   (operate_pulse),
    .mem_timeout     (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic       adv;
    logic       mrd;
    logic       dv;
    logic       err;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  exp_t       cur_e;
  logic [7:0] x_at, x_en, x_dv;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur_e = sb_q.pop_front();
      x_at  = cur_e.err ? 8'h00 : (8'h01 << cur_e.ph);
      x_en  = cur_e.adv ? (8'h01 << ((int'(cur_e.ph) + 1) % 8)) : 8'h00;
      x_dv  = cur_e.dv ? (8'h01 << cur_e.ph) : 8'h00;
      check_eq("cur_phase", 32'(cur_phase), 32'(cur_e.ph));
      check_eq("at_phase", 32'(at_phase), 32'(x_at));
      check_eq("entering_phase", 32'(entering_phase), 32'(x_en));
      check_eq("mem_read", 32'(mem_read), 32'(cur_e.mrd));
      check_eq("mem_data_valid", 32'(mem_data_valid), 32'(x_dv));
      check_eq("operate_pulse", 32'(operate_pulse), 32'(!cur_e.err && cur_e.ph == 3'd7));
      check_eq("mem_timeout", 32'(mem_timeout), 32'(cur_e.tmo));
    end
  end

  // Drive one cycle of inputs and queue what the outputs must show during it.
  task automatic cyc(input logic [7:0] ws, input logic [7:0] mr, input logic sp,
                     input logic rp, input logic ec, input int ph, input logic adv,
                     input logic mrd, input logic dv, input logic err = 1'b0,
                     input logic tmo = 1'b0);
    exp_t e;
    wait_start_mask = ws;
    mem_read_mask   = mr;
    start_pulse     = sp;
    mem_reply       = rp;
    err_clear       = ec;
    e.ph  = 3'(ph);
    e.adv = adv;
    e.mrd = mrd;
    e.dv  = dv;
    e.err = err;
    e.tmo = tmo;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Phases with no wait in effect: one cycle each.
  task automatic pass_phases(input logic [7:0] ws, input logic [7:0] mr, input int from,
                             input int to);
    for (int p = from; p <= to; p++) cyc(ws, mr, 1'b0, 1'b0, 1'b0, p % 8, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn          = 1'b0;
    wait_start_mask = '0;
    mem_read_mask   = '0;
    start_pulse     = 1'b0;
    mem_reply       = 1'b0;
    err_clear       = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // All masks zero: two full laps, one phase per cycle.
    pass_phases(8'h00, 8'h00, 0, 15);
    do_reset();

    // Start waits on phases 0 and 2; a start in phase 1 must not be remembered.
    for (int i = 0; i < 3; i++) cyc(8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    cyc(8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    cyc(8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    pass_phases(8'h05, 8'h00, 3, 7);
    do_reset();

    // Read at phase 1, reply 4 cycles later; next lap the reply coincides with mem_read.
    pass_phases(8'h00, 8'h02, 0, 0);
    cyc(8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    pass_phases(8'h00, 8'h02, 2, 8);
    cyc(8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1);
    pass_phases(8'h00, 8'h02, 2, 2);
    do_reset();

    // Phase 4 needs start and reply: start first, reply first, then both together.
    pass_phases(8'h10, 8'h10, 0, 3);
    cyc(8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    cyc(8'h10, 8'h10, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    cyc(8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    cyc(8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1);
    cyc(8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0);
    pass_phases(8'h10, 8'h10, 6, 11);
    cyc(8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    cyc(8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    pass_phases(8'h10, 8'h10, 5, 11);
    cyc(8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    cyc(8'h10, 8'h10, 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1);
    pass_phases(8'h10, 8'h10, 5, 5);
    do_reset();

    // Reset while phase 5 holds a start and awaits its reply; the stale reply is ignored.
    pass_phases(8'h20, 8'h20, 0, 4);
    cyc(8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0);
    cyc(8'h20, 8'h20, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0);
    start_pulse = 1'b0;
    mem_reply   = 1'b1;
    do_reset();
    cyc(8'h20, 8'h20, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    pass_phases(8'h20, 8'h20, 1, 4);
    cyc(8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0);
    cyc(8'h20, 8'h20, 1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1);
    cyc(8'h20, 8'h20, 1'b1, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0);
    pass_phases(8'h20, 8'h20, 6, 6);
    do_reset();

`ifdef PULSE_SEQ_TIMEOUT_EN
    // Reply on the limit cycle wins.
    pass_phases(8'h00, 8'h08, 0, 2);
    cyc(8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'h08, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    do_reset();

    // No reply: error after 6 cycles in phase 3, then recovery via err_clear.
    pass_phases(8'h00, 8'h08, 0, 2);
    cyc(8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'h08, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 8'h08, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    pass_phases(8'h00, 8'h00, 0, 1);
`endif

    @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
